secure_fifo_sequencer: RTL and testbench

Controller for the three-FIFO encrypt/decrypt datapath.
- Input FIFO2 feeds the encrypt stage into FIFO1; FIFO1 feeds the decrypt stage into FIFO3.
- The block replaces hand-driven wr1/rd1/wr2/rd2/wr3/rd3 strobes with a batch FSM: load N words into FIFO2, move them FIFO2→FIFO1, then FIFO1→FIFO3, then drain FIFO3.
- It drives only the strobes. The datapath owns data and key.

---
 rtl/secure_fifo_sequencer.sv | 140 ++++++++++++++
 tb/tb_secure_fifo_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/secure_fifo_sequencer.sv
// Batch sequencer for the FIFO2 -> encrypt -> FIFO1 -> decrypt -> FIFO3 datapath.
// Drives only the FIFO strobes; data and key stay in the datapath.
module secure_fifo_sequencer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             empty1,
    input  logic             full1,
    input  logic             empty2,
    input  logic             full2,
    input  logic             empty3,
    input  logic             full3,
    output logic             wr1,
    output logic             rd1,
    output logic             wr2,
    output logic             rd2,
    output logic             wr3,
    output logic             rd3,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_RD2, S_WR1, S_RD1,
        S_WR3, S_RD3, S_VAL3, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] n_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;

    assign cnt_inc = cnt_q + 1'b1;
    assign last    = (cnt_inc == n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q   <= word_count;
                        cnt_q <= '0;
                        err_q <= 1'b0;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                        end else if (word_count > DEPTH_C) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (wr2) begin
                        if (last) begin
                            cnt_q   <= '0;
                            state_q <= S_RD2;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                S_RD2: begin
                    if (empty2) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else if (!full1) begin
                        state_q <= S_WR1;
                    end
                end
                S_WR1: begin
                    cnt_q   <= last ? '0 : cnt_inc;
                    state_q <= last ? S_RD1 : S_RD2;
                end
                S_RD1: begin
                    if (empty1) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else if (!full3) begin
                        state_q <= S_WR3;
                    end
                end
                S_WR3: begin
                    cnt_q   <= last ? '0 : cnt_inc;
                    state_q <= last ? S_RD3 : S_RD1;
                end
                S_RD3: begin
                    if (empty3) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_VAL3;
                    end
                end
                S_VAL3: begin
                    cnt_q   <= last ? '0 : cnt_inc;
                    state_q <= last ? S_DONE : S_RD3;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Reads are withheld on underflow or downstream-full so no strobe leaks.
    assign in_ready  = (state_q == S_LOAD) & ~full2;
    assign wr2       = in_valid & in_ready;
    assign rd2       = (state_q == S_RD2) & ~empty2 & ~full1;
    assign wr1       = (state_q == S_WR1);
    assign rd1       = (state_q == S_RD1) & ~empty1 & ~full3;
    assign wr3       = (state_q == S_WR3);
    assign rd3       = (state_q == S_RD3) & ~empty3;
    assign out_valid = (state_q == S_VAL3);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_secure_fifo_sequencer.sv
// Directed bench for secure_fifo_sequencer: per-cycle output traces
// are recorded as bitmasks (bit c = cycle c after start) and compared.
module tb_secure_fifo_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] word_count;
    logic       in_valid;
    logic       in_ready;
    logic       empty1, full1, empty2, full2, empty3, full3;
    logic       wr1, rd1, wr2, rd2, wr3, rd3;
    logic       out_valid, busy, done, err;

    int tests = 0;
    int fails = 0;
    int excl_viol = 0;

    logic [63:0] r_wr2, r_rd2, r_wr1, r_rd1, r_wr3, r_rd3;
    logic [63:0] r_ov, r_done, r_busy, r_err, r_ir, r_any;

    secure_fifo_sequencer #(.DEPTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_ready(in_ready),
        .empty1(empty1), .full1(full1), .empty2(empty2), .full2(full2),
        .empty3(empty3), .full3(full3),
        .wr1(wr1), .rd1(rd1), .wr2(wr2), .rd2(rd2), .wr3(wr3), .rd3(rd3),
        .out_valid(out_valid), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run(input logic [4:0] n, input logic [63:0] st,
                       input logic [63:0] iv, input logic [63:0] f1,
                       input logic [63:0] e2, input logic [63:0] rs,
                       input int ncyc);
        int nr, nw;
        r_wr2 = '0; r_rd2 = '0; r_wr1 = '0; r_rd1 = '0;
        r_wr3 = '0; r_rd3 = '0; r_ov = '0; r_done = '0;
        r_busy = '0; r_err = '0; r_ir = '0; r_any = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            word_count = n;
            start = st[c]; in_valid = iv[c]; full1 = f1[c];
            empty2 = e2[c]; rst = rs[c];
            #1;
            r_wr2[c] = wr2; r_rd2[c] = rd2; r_wr1[c] = wr1;
            r_rd1[c] = rd1; r_wr3[c] = wr3; r_rd3[c] = rd3;
            r_ov[c] = out_valid; r_done[c] = done; r_busy[c] = busy;
            r_err[c] = err; r_ir[c] = in_ready;
            r_any[c] = wr2 | rd2 | wr1 | rd1 | wr3 | rd3 | out_valid;
            nr = int'(rd1) + int'(rd2) + int'(rd3);
            nw = int'(wr1) + int'(wr2) + int'(wr3);
            if (nr > 1 || nw > 1 || (rd1 & wr1) || (rd2 & wr2) || (rd3 & wr3))
                excl_viol++;
        end
        @(negedge clk);
        start = 0; in_valid = 0; full1 = 0; empty2 = 0; rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; start = 1; in_valid = 1; word_count = 5'd2;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if ({in_ready, wr2, rd2, wr1, rd1, wr3, rd3, out_valid, busy, done, err} !== 11'b0) begin
            fails++;
            $display("FAIL reset_outputs got %b exp 0",
                     {in_ready, wr2, rd2, wr1, rd1, wr3, rd3, out_valid, busy, done, err});
        end
        @(negedge clk);
        rst = 0; start = 0; in_valid = 0;
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_nominal();
        run(5'd2, 64'h1, '1, '0, '0, '0, 20);
        tests++; if (r_wr2 !== 64'h6) begin fails++; $display("FAIL nom_wr2 got %h exp %h", r_wr2, 64'h6); end
        tests++; if (r_rd2 !== 64'h28) begin fails++; $display("FAIL nom_rd2 got %h exp %h", r_rd2, 64'h28); end
        tests++; if (r_wr1 !== 64'h50) begin fails++; $display("FAIL nom_wr1 got %h exp %h", r_wr1, 64'h50); end
        tests++; if (r_rd1 !== 64'h280) begin fails++; $display("FAIL nom_rd1 got %h exp %h", r_rd1, 64'h280); end
        tests++; if (r_wr3 !== 64'h500) begin fails++; $display("FAIL nom_wr3 got %h exp %h", r_wr3, 64'h500); end
        tests++; if (r_rd3 !== 64'h2800) begin fails++; $display("FAIL nom_rd3 got %h exp %h", r_rd3, 64'h2800); end
        tests++; if (r_ov !== 64'h5000) begin fails++; $display("FAIL nom_ov got %h exp %h", r_ov, 64'h5000); end
        tests++; if (r_done !== 64'h8000) begin fails++; $display("FAIL nom_done got %h exp %h", r_done, 64'h8000); end
        tests++; if (r_busy !== 64'hFFFE) begin fails++; $display("FAIL nom_busy got %h exp %h", r_busy, 64'hFFFE); end
        tests++; if (r_ir !== 64'h6) begin fails++; $display("FAIL nom_in_ready got %h exp %h", r_ir, 64'h6); end
        tests++; if (r_err !== 64'h0) begin fails++; $display("FAIL nom_err got %h exp 0", r_err); end
    endtask

    task automatic test_source_gaps();
        run(5'd3, 64'h1, 64'hAAAA_AAAA_AAAA_AAAA, '0, '0, '0, 28);
        tests++; if (r_wr2 !== 64'h2A) begin fails++; $display("FAIL gap_wr2 got %h exp %h", r_wr2, 64'h2A); end
        tests++; if (r_rd2 !== 64'h540) begin fails++; $display("FAIL gap_rd2 got %h exp %h", r_rd2, 64'h540); end
        tests++; if (r_wr1 !== 64'hA80) begin fails++; $display("FAIL gap_wr1 got %h exp %h", r_wr1, 64'hA80); end
        tests++; if (r_done !== 64'h100_0000) begin fails++; $display("FAIL gap_done got %h exp %h", r_done, 64'h100_0000); end
        tests++; if (r_busy !== 64'h1FF_FFFE) begin fails++; $display("FAIL gap_busy got %h exp %h", r_busy, 64'h1FF_FFFE); end
    endtask

    task automatic test_backpressure();
        run(5'd2, 64'h1, '1, 64'h78, '0, '0, 24);
        tests++; if (r_rd2 !== 64'h280) begin fails++; $display("FAIL bp_rd2 got %h exp %h", r_rd2, 64'h280); end
        tests++; if (r_wr1 !== 64'h500) begin fails++; $display("FAIL bp_wr1 got %h exp %h", r_wr1, 64'h500); end
        tests++; if (r_done !== 64'h8_0000) begin fails++; $display("FAIL bp_done got %h exp %h", r_done, 64'h8_0000); end
    endtask

    task automatic test_start_held();
        run(5'd2, 64'h7FFF, '1, '0, '0, '0, 20);
        tests++; if (r_wr2 !== 64'h6) begin fails++; $display("FAIL held_wr2 got %h exp %h", r_wr2, 64'h6); end
        tests++; if (r_rd3 !== 64'h2800) begin fails++; $display("FAIL held_rd3 got %h exp %h", r_rd3, 64'h2800); end
        tests++; if (r_done !== 64'h8000) begin fails++; $display("FAIL held_done got %h exp %h", r_done, 64'h8000); end
    endtask

    task automatic test_n_zero();
        run(5'd0, 64'h1, '1, '0, '0, '0, 4);
        tests++; if (r_done !== 64'h2) begin fails++; $display("FAIL n0_done got %h exp %h", r_done, 64'h2); end
        tests++; if (r_any !== 64'h0) begin fails++; $display("FAIL n0_strobes got %h exp 0", r_any); end
        tests++; if (r_err !== 64'h0) begin fails++; $display("FAIL n0_err got %h exp 0", r_err); end
    endtask

    task automatic test_n_over();
        run(5'd17, 64'h1, '1, '0, '0, '0, 8);
        tests++; if (r_done !== 64'h2) begin fails++; $display("FAIL over_done got %h exp %h", r_done, 64'h2); end
        tests++; if (r_err !== 64'hFE) begin fails++; $display("FAIL over_err got %h exp %h", r_err, 64'hFE); end
        tests++; if (r_any !== 64'h0) begin fails++; $display("FAIL over_strobes got %h exp 0", r_any); end
    endtask

    task automatic test_underflow();
        // err is still set from the previous oversize batch at cycle 0
        run(5'd2, 64'h1, '1, '0, 64'h8, '0, 10);
        tests++; if (r_err !== 64'h3F1) begin fails++; $display("FAIL uf_err got %h exp %h", r_err, 64'h3F1); end
        tests++; if (r_done !== 64'h10) begin fails++; $display("FAIL uf_done got %h exp %h", r_done, 64'h10); end
        tests++; if ((r_rd2 | r_wr1) !== 64'h0) begin fails++; $display("FAIL uf_rd2 got %h exp 0", r_rd2 | r_wr1); end
        run(5'd1, 64'h1, '1, '0, '0, '0, 10);
        tests++; if (r_err !== 64'h1) begin fails++; $display("FAIL uf_clear got %h exp %h", r_err, 64'h1); end
        tests++; if (r_done !== 64'h100) begin fails++; $display("FAIL uf_next_done got %h exp %h", r_done, 64'h100); end
    endtask

    task automatic test_reset_mid();
        run(5'd2, 64'h1, '1, '0, '0, 64'h10, 8);
        tests++; if (r_busy !== 64'h1E) begin fails++; $display("FAIL rmid_busy got %h exp %h", r_busy, 64'h1E); end
        tests++; if (r_any !== 64'h1E) begin fails++; $display("FAIL rmid_strobes got %h exp %h", r_any, 64'h1E); end
        tests++; if (r_done !== 64'h0) begin fails++; $display("FAIL rmid_done got %h exp 0", r_done); end
        run(5'd1, 64'h1, '1, '0, '0, '0, 10);
        tests++; if (r_wr2 !== 64'h2) begin fails++; $display("FAIL rnew_wr2 got %h exp %h", r_wr2, 64'h2); end
        tests++; if (r_rd3 !== 64'h40) begin fails++; $display("FAIL rnew_rd3 got %h exp %h", r_rd3, 64'h40); end
        tests++; if (r_ov !== 64'h80) begin fails++; $display("FAIL rnew_ov got %h exp %h", r_ov, 64'h80); end
        tests++; if (r_done !== 64'h100) begin fails++; $display("FAIL rnew_done got %h exp %h", r_done, 64'h100); end
        tests++; if (r_busy !== 64'h1FE) begin fails++; $display("FAIL rnew_busy got %h exp %h", r_busy, 64'h1FE); end
    endtask

    task automatic test_exclusion();
        tests++;
        if (excl_viol !== 0) begin
            fails++; $display("FAIL mutex got %0d violations exp 0", excl_viol);
        end
    endtask

    initial begin
        rst = 1; start = 0; word_count = '0; in_valid = 0;
        empty1 = 0; full1 = 0; empty2 = 0; full2 = 0; empty3 = 0; full3 = 0;
        test_reset();
        test_nominal();
        test_source_gaps();
        test_backpressure();
        test_start_held();
        test_n_zero();
        test_n_over();
        test_underflow();
        test_reset_mid();
        test_exclusion();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
